// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates IF and MEM onto a byte-wide RAM bus and serialises 8/16/32-bit accesses.
// Optional one-entry fetch buffer is enabled by defining MEM_CTRL_IF_BUF_EN.
//
// state  | meaning
// IDLE   | sample requests, latch the winning access
// IF_RD  | fetch bytes 0..3, one extra cycle to capture the last byte
// MEM_RD | load bytes 0..N-1, one extra cycle to capture the last byte
// MEM_WR | store bytes 0..N-1
// DONE   | owner's done pulse with rdata registered
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [2:0]  len_q, len_mem;
    logic [31:0] base, wdata_q, result, result_nx;
    logic [31:0] if_rdata_q, mem_rdata_q, ram_addr_q;
    logic        owner_mem;
    logic        acc_mem, acc_if, capture, rd_finish, bus_active;

`ifdef MEM_CTRL_IF_BUF_EN
    logic [31:0] buf_tag, buf_data;
    logic        buf_valid, buf_hit;

    assign buf_hit = (state == IDLE) && !mem_req && if_req && !if_cancel &&
                     buf_valid && (if_addr == buf_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (acc_mem && mem_we) begin
            buf_valid <= 1'b0;
        end else if (rd_finish && !owner_mem) begin
            buf_valid <= 1'b1;
            buf_tag   <= base;
            buf_data  <= result_nx;
        end
    end
`else
    logic [31:0] buf_data;
    logic        buf_hit;
    assign buf_data = '0;
    assign buf_hit  = 1'b0;
`endif

    // MEM wins arbitration: it belongs to the older instruction
    assign acc_mem = (state == IDLE) && mem_req;
    assign acc_if  = (state == IDLE) && !mem_req && if_req && !if_cancel && !buf_hit;

    always_comb begin
        case (mem_width)
            2'd0:    len_mem = 3'd1;
            2'd1:    len_mem = 3'd2;
            default: len_mem = 3'd4;
        endcase
    end

    assign capture   = ((state == IF_RD && !if_cancel) || state == MEM_RD) && (cnt != 3'd0);
    assign rd_finish = capture && (cnt == len_q);

    always_comb begin
        result_nx = result;
        case (cnt)
            3'd1:    result_nx[7:0]   = ram_rdata;
            3'd2:    result_nx[15:8]  = ram_rdata;
            3'd3:    result_nx[23:16] = ram_rdata;
            3'd4:    result_nx[31:24] = ram_rdata;
            default: result_nx = result;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = 3'd0;
        case (state)
            IDLE: begin
                if (acc_mem)
                    state_nx = mem_we ? MEM_WR : MEM_RD;
                else if (buf_hit)
                    state_nx = DONE;
                else if (acc_if)
                    state_nx = IF_RD;
            end
            IF_RD: begin
                if (if_cancel)
                    state_nx = IDLE;
                else if (cnt == len_q)
                    state_nx = DONE;
                else
                    cnt_nx = cnt + 3'd1;
            end
            MEM_RD: begin
                if (cnt == len_q)
                    state_nx = DONE;
                else
                    cnt_nx = cnt + 3'd1;
            end
            MEM_WR: begin
                if (cnt == len_q - 3'd1)
                    state_nx = DONE;
                else
                    cnt_nx = cnt + 3'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            len_q       <= 3'd0;
            base        <= '0;
            wdata_q     <= '0;
            result      <= '0;
            owner_mem   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            ram_addr_q  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            ram_addr_q <= ram_addr;
            if (acc_mem) begin
                base      <= mem_addr;
                len_q     <= len_mem;
                wdata_q   <= mem_wdata;
                owner_mem <= 1'b1;
                result    <= '0;
            end else if (acc_if) begin
                base      <= if_addr;
                len_q     <= 3'd4;
                owner_mem <= 1'b0;
                result    <= '0;
            end else if (buf_hit) begin
                owner_mem  <= 1'b0;
                if_rdata_q <= buf_data;
            end
            if (capture)
                result <= result_nx;
            if (rd_finish) begin
                if (owner_mem)
                    mem_rdata_q <= result_nx;
                else
                    if_rdata_q <= result_nx;
            end
        end
    end

    // Address is driven only while a byte is being issued; otherwise it holds
    assign bus_active = (state == IF_RD || state == MEM_RD || state == MEM_WR) && (cnt < len_q);
    assign ram_addr   = bus_active ? (base + {29'd0, cnt}) : ram_addr_q;
    assign ram_wr     = (state == MEM_WR);

    always_comb begin
        ram_wdata = 8'h00;
        if (ram_wr) begin
            case (cnt[1:0])
                2'd0:    ram_wdata = wdata_q[7:0];
                2'd1:    ram_wdata = wdata_q[15:8];
                2'd2:    ram_wdata = wdata_q[23:16];
                default: ram_wdata = wdata_q[31:24];
            endcase
        end
    end

    assign if_done      = (state == DONE) && !owner_mem && !if_cancel;
    assign mem_done     = (state == DONE) && owner_mem;
    assign if_rdata     = if_rdata_q;
    assign mem_rdata    = mem_rdata_q;
    assign stallreq_if  = if_req & ~if_done;
    assign stallreq_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model; buffer checks follow MEM_CTRL_IF_BUF_EN.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_cancel, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [1:0]  mem_width;
   logic [31:0] if_rdata, mem_rdata, ram_addr;
   logic        if_done, mem_done, ram_wr, stallreq_if, stallreq_mem;
   logic [7:0]  ram_wdata, ram_rdata;

   logic [7:0]  ram [0:4095];
   logic        pl_we = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;

   int checks = 0;
   int failures = 0;
   logic [31:0] addr_snap;

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
      .if_rdata(if_rdata), .if_done(if_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
   );

   always @(posedge clk) begin
      ram_rdata <= ram[ram_addr[11:0]];
      if (ram_wr)
         ram[ram_addr[11:0]] <= ram_wdata;
      else if (pl_we)
         ram[pl_addr] <= pl_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      cyc();
      pl_we = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input int lat);
      if_req = 1'b1; if_addr = a;
      for (int k = 1; k <= lat; k++) begin
         cyc(); smp();
         chk("fetch_done", if_done, (k == lat));
      end
      chk("fetch_data", if_rdata, exp);
      cyc(); if_req = 1'b0;
   endtask

   initial begin
      #200000;
      failures++;
      $error("FAIL timeout: bench did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; if_cancel = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_width = 2'd0; mem_addr = '0; mem_wdata = '0;
      repeat (2) cyc();
      rst = 1'b0;
      smp();
      chk("rst_ram_addr", ram_addr, 32'h0);
      chk("rst_ram_wr", ram_wr, 1'b0);
      chk("rst_ram_wdata", ram_wdata, 8'h00);
      chk("rst_if_done", if_done, 1'b0);
      chk("rst_mem_done", mem_done, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      cyc();

      preload(12'h100, 8'h13); preload(12'h101, 8'h05);
      preload(12'h102, 8'hA0); preload(12'h103, 8'h00);
      preload(12'h104, 8'h93); preload(12'h105, 8'h00);
      preload(12'h106, 8'h10); preload(12'h107, 8'h00);
      preload(12'h200, 8'hFF); preload(12'h302, 8'h77);
      preload(12'h402, 8'h55);

      if_req = 1'b1; if_addr = 32'h100;
      smp();
      chk("wf_stall0", stallreq_if, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         cyc(); smp();
         chk("wf_addr", ram_addr, 32'h100 + k - 1);
         chk("wf_wr", ram_wr, 1'b0);
      end
      cyc(); smp();
      chk("wf_done5", if_done, 1'b0);
      cyc(); smp();
      chk("wf_done6", if_done, 1'b1);
      chk("wf_data", if_rdata, 32'h00A00513);
      chk("wf_stall6", stallreq_if, 1'b0);
      cyc(); if_req = 1'b0; smp();
      chk("wf_done7", if_done, 1'b0);
      chk("wf_hold", ram_addr, 32'h103);
      cyc();

      if_req = 1'b1; if_addr = 32'h104;
      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h200;
      smp();
      chk("cf_stall_if", stallreq_if, 1'b1);
      chk("cf_stall_mem", stallreq_mem, 1'b1);
      cyc(); smp();
      chk("cf_addr1", ram_addr, 32'h200);
      cyc(); smp();
      chk("cf_done2", mem_done, 1'b0);
      cyc(); smp();
      chk("cf_mem_done3", mem_done, 1'b1);
      chk("cf_mem_data", mem_rdata, 32'h000000FF);
      chk("cf_if_done3", if_done, 1'b0);
      chk("cf_stall_mem3", stallreq_mem, 1'b0);
      cyc(); mem_req = 1'b0; smp();
      chk("cf_mem_done4", mem_done, 1'b0);
      cyc(); smp();
      chk("cf_if_addr5", ram_addr, 32'h104);
      for (int k = 6; k <= 10; k++) begin
         cyc(); smp();
         chk("cf_if_done", if_done, (k == 10));
      end
      chk("cf_if_data", if_rdata, 32'h00100093);
      cyc(); if_req = 1'b0;

      mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd1; mem_addr = 32'h300; mem_wdata = 32'hDEAD1234;
      smp();
      chk("hs_stall0", stallreq_mem, 1'b1);
      chk("hs_wr0", ram_wr, 1'b0);
      cyc(); smp();
      chk("hs_wr1", ram_wr, 1'b1);
      chk("hs_addr1", ram_addr, 32'h300);
      chk("hs_data1", ram_wdata, 8'h34);
      chk("hs_stall1", stallreq_mem, 1'b1);
      cyc(); smp();
      chk("hs_wr2", ram_wr, 1'b1);
      chk("hs_addr2", ram_addr, 32'h301);
      chk("hs_data2", ram_wdata, 8'h12);
      chk("hs_stall2", stallreq_mem, 1'b1);
      cyc(); smp();
      chk("hs_wr3", ram_wr, 1'b0);
      chk("hs_done3", mem_done, 1'b1);
      chk("hs_stall3", stallreq_mem, 1'b0);
      cyc(); mem_req = 1'b0; smp();
      chk("hs_ram300", ram[12'h300], 8'h34);
      chk("hs_ram301", ram[12'h301], 8'h12);
      chk("hs_ram302", ram[12'h302], 8'h77);
      cyc();

      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd1; mem_addr = 32'h300;
      for (int k = 1; k <= 4; k++) begin
         cyc(); smp();
         chk("hl_done", mem_done, (k == 4));
      end
      chk("hl_data", mem_rdata, 32'h00001234);
      cyc(); mem_req = 1'b0;

      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd3; mem_addr = 32'h104;
      for (int k = 1; k <= 6; k++) begin
         cyc(); smp();
         chk("wl_done", mem_done, (k == 6));
      end
      chk("wl_data", mem_rdata, 32'h00100093);
      cyc(); mem_req = 1'b0;

      if_req = 1'b1; if_addr = 32'h100;
      cyc();
      cyc(); if_cancel = 1'b1; if_req = 1'b0;
      mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'd0; mem_addr = 32'h200;
      smp();
      chk("cn_done2", if_done, 1'b0);
      cyc(); if_cancel = 1'b0; smp();
      chk("cn_if_done3", if_done, 1'b0);
      chk("cn_mem_done3", mem_done, 1'b0);
      cyc(); smp();
      chk("cn_addr4", ram_addr, 32'h200);
      chk("cn_if_done4", if_done, 1'b0);
      cyc(); smp();
      chk("cn_if_done5", if_done, 1'b0);
      cyc(); smp();
      chk("cn_mem_done6", mem_done, 1'b1);
      chk("cn_if_done6", if_done, 1'b0);
      cyc(); mem_req = 1'b0;

      if_req = 1'b1; if_addr = 32'h100;
      repeat (6) cyc();
      if_cancel = 1'b1;
      smp();
      chk("cd_done", if_done, 1'b0);
      cyc(); if_cancel = 1'b0; if_req = 1'b0; smp();
      chk("cd_done7", if_done, 1'b0);
      cyc();

      mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd2; mem_addr = 32'h400; mem_wdata = 32'hAABBCCDD;
      cyc(); smp();
      chk("rs_wr1", ram_wr, 1'b1);
      chk("rs_data1", ram_wdata, 8'hDD);
      cyc(); rst = 1'b1; smp();
      chk("rs_addr2", ram_addr, 32'h401);
      cyc(); rst = 1'b0; mem_req = 1'b0; smp();
      chk("rs_wr3", ram_wr, 1'b0);
      chk("rs_addr3", ram_addr, 32'h0);
      chk("rs_wdata3", ram_wdata, 8'h00);
      chk("rs_done3", mem_done, 1'b0);
      chk("rs_if_rdata3", if_rdata, 32'h0);
      chk("rs_mem_rdata3", mem_rdata, 32'h0);
      for (int k = 4; k <= 6; k++) begin
         cyc(); smp();
         chk("rs_done_late", mem_done, 1'b0);
      end
      chk("rs_ram400", ram[12'h400], 8'hDD);
      chk("rs_ram401", ram[12'h401], 8'hCC);
      chk("rs_ram402", ram[12'h402], 8'h55);
      cyc();

      do_fetch(32'h100, 32'h00A00513, 6);
      smp(); addr_snap = ram_addr;
      cyc();
`ifdef MEM_CTRL_IF_BUF_EN
      if_req = 1'b1; if_addr = 32'h100;
      cyc(); smp();
      chk("bf_hit_done", if_done, 1'b1);
      chk("bf_hit_data", if_rdata, 32'h00A00513);
      chk("bf_hit_addr", ram_addr, addr_snap);
      cyc(); if_req = 1'b0; smp();
      chk("bf_hit_addr2", ram_addr, addr_snap);
      cyc();
`else
      do_fetch(32'h100, 32'h00A00513, 6);
`endif
      mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'd0; mem_addr = 32'h500; mem_wdata = 32'h5A;
      repeat (2) cyc();
      smp();
      chk("bf_st_done", mem_done, 1'b1);
      cyc(); mem_req = 1'b0;
      do_fetch(32'h100, 32'h00A00513, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
